// File: rtl/ct_f_spsram_arb_init_if.sv
// Requester-side access port: request fields, same-cycle grant, and the
// read response that returns one cycle after a granted read.
interface ct_f_spsram_arb_init_if #(
    parameter int unsigned ADDR_WIDTH = 9,
    parameter int unsigned DATA_WIDTH = 54
);
    logic                  vld;
    logic                  wr;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] wmask;
    logic                  gnt;
    logic                  rvld;
    logic [DATA_WIDTH-1:0] rdata;

    modport master (output vld, wr, addr, wdata, wmask, input  gnt, rvld, rdata);
    modport slave  (input  vld, wr, addr, wdata, wmask, output gnt, rvld, rdata);
endinterface

// File: rtl/ct_f_spsram_arb_init.sv
// Single-port SRAM front end: init sweep after reset or on request, then
// round-robin arbitration of two requesters with read data routed back to its owner.
module ct_f_spsram_arb_init #(
    parameter int unsigned           ADDR_WIDTH = 9,
    parameter int unsigned           DATA_WIDTH = 54,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  init_start,
    output logic                  init_busy,
    output logic                  init_done,
    ct_f_spsram_arb_init_if.slave req0,
    ct_f_spsram_arb_init_if.slave req1,
    output logic [ADDR_WIDTH-1:0] sram_a,
    output logic                  sram_cen,
    output logic                  sram_gwen,
    output logic [DATA_WIDTH-1:0] sram_wen,
    output logic [DATA_WIDTH-1:0] sram_d,
    input  logic [DATA_WIDTH-1:0] sram_q
);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    typedef enum logic {ST_INIT, ST_RUN} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  rr_q, rr_d;
    logic                  rvld_q, rvld_d;
    logic                  owner_q, owner_d;
    logic                  done_q, done_d;

    logic                  gnt0, gnt1, sel;
    logic                  r0_vld, r1_vld;

    // Next state, arbitration and SRAM drive; everything idles while RST is high.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rr_d      = rr_q;
        rvld_d    = 1'b0;
        owner_d   = owner_q;
        done_d    = done_q;
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        sel       = 1'b0;
        sram_a    = '0;
        sram_cen  = 1'b1;
        sram_gwen = 1'b1;
        sram_wen  = '1;
        sram_d    = '0;
        if (!RST) begin
            unique case (state_q)
                ST_INIT: begin
                    sram_a    = cnt_q;
                    sram_cen  = 1'b0;
                    sram_gwen = 1'b0;
                    sram_wen  = '0;
                    sram_d    = INIT_VALUE;
                    cnt_d     = cnt_q + ADDR_WIDTH'(1);
                    if (cnt_q == LAST_ADDR) begin
                        state_d = ST_RUN;
                        done_d  = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (init_start) begin
                        state_d = ST_INIT;
                        cnt_d   = '0;
                        done_d  = 1'b0;
                    end else if (req0.vld || req1.vld) begin
                        // Contention goes to the pointer; either way the pointer
                        // then names the requester that was not served.
                        sel      = (req0.vld && req1.vld) ? rr_q : req1.vld;
                        gnt0     = ~sel;
                        gnt1     = sel;
                        rr_d     = ~sel;
                        sram_a   = sel ? req1.addr : req0.addr;
                        sram_cen = 1'b0;
                        if (sel ? req1.wr : req0.wr) begin
                            sram_gwen = 1'b0;
                            sram_wen  = sel ? ~req1.wmask : ~req0.wmask;
                            sram_d    = sel ? req1.wdata : req0.wdata;
                        end else begin
                            rvld_d  = 1'b1;
                            owner_d = sel;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
            rr_q    <= 1'b0;
            rvld_q  <= 1'b0;
            owner_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rr_q    <= rr_d;
            rvld_q  <= rvld_d;
            owner_q <= owner_d;
            done_q  <= done_d;
        end
    end

    assign init_busy  = RST | (state_q == ST_INIT);
    assign init_done  = done_q & ~RST;

    assign r0_vld     = rvld_q & ~owner_q & ~RST;
    assign r1_vld     = rvld_q &  owner_q & ~RST;

    assign req0.gnt   = gnt0;
    assign req1.gnt   = gnt1;
    assign req0.rvld  = r0_vld;
    assign req1.rvld  = r1_vld;
    assign req0.rdata = r0_vld ? sram_q : '0;
    assign req1.rdata = r1_vld ? sram_q : '0;
endmodule

// File: tb/tb_ct_f_spsram_arb_init.sv
// Bench for ct_f_spsram_arb_init: behavioural SRAM, directed stimulus and a
// read-response scoreboard checked by an independent monitor.
module tb_ct_f_spsram_arb_init;
    localparam int unsigned AW = 9;
    localparam int unsigned DW = 54;
    localparam logic [DW-1:0] VAL_A = 54'h2A_AAAA_5555;
    localparam logic [DW-1:0] VAL_B = 54'h12_3456_789A;
    localparam logic [DW-1:0] VAL_C = 54'h155;
    localparam logic [DW-1:0] VAL_D = 54'h3A_5A5A_0F0F;
    localparam logic [DW-1:0] ONES  = '1;

    typedef struct {
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          RST;
    logic          init_start;
    logic          init_busy, init_done;
    logic [AW-1:0] sram_a;
    logic          sram_cen, sram_gwen;
    logic [DW-1:0] sram_wen, sram_d, sram_q;
    logic [DW-1:0] mem [0:(1<<AW)-1];

    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    exp_t q0[$];
    exp_t q1[$];

    ct_f_spsram_arb_init_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) r0 ();
    ct_f_spsram_arb_init_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) r1 ();

    ct_f_spsram_arb_init dut (
        .CLK(clk), .RST(RST), .init_start(init_start),
        .init_busy(init_busy), .init_done(init_done),
        .req0(r0), .req1(r1),
        .sram_a(sram_a), .sram_cen(sram_cen), .sram_gwen(sram_gwen),
        .sram_wen(sram_wen), .sram_d(sram_d), .sram_q(sram_q)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Behavioural 1-cycle-latency SRAM with active-low per-bit write enable.
    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = ONES;
        sram_q = '0;
    end
    always @(posedge clk) begin
        if (!sram_cen) begin
            if (!sram_gwen) mem[sram_a] <= (mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
            else            sram_q      <= mem[sram_a];
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Read-response monitor: pops expectations, checks data, latency and exclusivity.
    always @(negedge clk) begin
        exp_t e;
        chk("rvld_onehot", 64'(r0.rvld & r1.rvld), 64'd0);
        if (r0.rvld) begin
            if (q0.size() == 0) chk("rvld0_unexpected", 64'(r0.rvld), 64'd0);
            else begin
                e = q0.pop_front();
                chk("rdata0", 64'(r0.rdata), 64'(e.data));
                chk("lat0", 64'(cyc), 64'(e.cyc));
            end
        end else begin
            chk("rdata0_idle", 64'(r0.rdata), 64'd0);
            if (q0.size() != 0 && q0[0].cyc <= cyc) begin
                chk("rvld0_missing", 64'(r0.rvld), 64'd1);
                void'(q0.pop_front());
            end
        end
        if (r1.rvld) begin
            if (q1.size() == 0) chk("rvld1_unexpected", 64'(r1.rvld), 64'd0);
            else begin
                e = q1.pop_front();
                chk("rdata1", 64'(r1.rdata), 64'(e.data));
                chk("lat1", 64'(cyc), 64'(e.cyc));
            end
        end else begin
            chk("rdata1_idle", 64'(r1.rdata), 64'd0);
            if (q1.size() != 0 && q1[0].cyc <= cyc) begin
                chk("rvld1_missing", 64'(r1.rvld), 64'd1);
                void'(q1.pop_front());
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sweep_check(input int k);
        @(negedge clk);
        chk("sweep_a", 64'(sram_a), 64'(k));
        chk("sweep_ctl", 64'({sram_cen, sram_gwen, init_busy, init_done, r0.gnt, r1.gnt}), 64'b001000);
        chk("sweep_wen", 64'(sram_wen), 64'd0);
        chk("sweep_d", 64'(sram_d), 64'd0);
    endtask

    task automatic idle_check(input string nm);
        chk(nm, 64'({sram_cen, sram_gwen, r0.gnt, r1.gnt}), 64'b1100);
        chk({nm, "_wen"}, 64'(sram_wen), 64'(ONES));
    endtask

    // Single-requester access; expects a grant within a bounded wait.
    task automatic access(input int id, input logic wr, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wd, input logic [DW-1:0] wm,
                          input logic [DW-1:0] exp);
        int            waitc = 0;
        logic          g;
        logic [DW-1:0] nwm = ~wm;
        exp_t          e;
        if (id == 0) begin r0.vld = 1; r0.wr = wr; r0.addr = addr; r0.wdata = wd; r0.wmask = wm; end
        else         begin r1.vld = 1; r1.wr = wr; r1.addr = addr; r1.wdata = wd; r1.wmask = wm; end
        @(negedge clk);
        g = (id == 0) ? r0.gnt : r1.gnt;
        while (!g && waitc < 2000) begin
            step();
            @(negedge clk);
            g = (id == 0) ? r0.gnt : r1.gnt;
            waitc++;
        end
        chk("acc_gnt", 64'(g), 64'd1);
        chk("acc_a", 64'(sram_a), 64'(addr));
        chk("acc_cen_gwen", 64'({sram_cen, sram_gwen}), 64'({1'b0, ~wr}));
        if (wr) begin
            chk("acc_wen", 64'(sram_wen), 64'(nwm));
            chk("acc_d", 64'(sram_d), 64'(wd));
        end else begin
            chk("acc_wen_rd", 64'(sram_wen), 64'(ONES));
            e.data = exp;
            e.cyc  = cyc + 1;
            if (id == 0) q0.push_back(e); else q1.push_back(e);
        end
        step();
        if (id == 0) r0.vld = 0; else r1.vld = 0;
    endtask

    initial begin
        exp_t e;
        RST = 1; init_start = 0;
        r0.vld = 0; r0.wr = 0; r0.addr = '0; r0.wdata = '0; r0.wmask = '0;
        r1.vld = 0; r1.wr = 0; r1.addr = '0; r1.wdata = '0; r1.wmask = '0;
        step();
        r0.vld = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            idle_check("rst_idle");
            chk("rst_a_d", 64'({sram_a, sram_d} != '0), 64'd0);
            chk("rst_busy_done", 64'({init_busy, init_done}), 64'b10);
            step();
        end
        r0.vld = 0;

        // Post-reset sweep; req0 write pending from cycle 10 must wait for RUN.
        RST = 0;
        for (int k = 0; k < 512; k++) begin
            if (k == 10) begin
                r0.vld = 1; r0.wr = 1; r0.addr = 9'd7; r0.wdata = 54'h15; r0.wmask = ONES;
            end
            sweep_check(k);
            step();
        end
        @(negedge clk);
        chk("run_busy_done", 64'({init_busy, init_done}), 64'b01);
        chk("first_gnt", 64'({r0.gnt, r1.gnt}), 64'b10);
        chk("first_wr", 64'({sram_a, sram_cen, sram_gwen}), 64'({9'd7, 2'b00}));
        chk("first_wr_d", 64'(sram_d), 64'h15);
        chk("first_wr_wen", 64'(sram_wen), 64'd0);
        step();
        r0.vld = 0;
        access(1, 1'b0, 9'd7, '0, '0, 54'h15);
        @(negedge clk);
        idle_check("idle_after");

        // Alternating grants under continuous contention.
        access(0, 1'b1, 9'd20, VAL_A, ONES, '0);
        access(1, 1'b1, 9'd21, VAL_B, ONES, '0);
        r0.vld = 1; r0.wr = 0; r0.addr = 9'd20;
        r1.vld = 1; r1.wr = 0; r1.addr = 9'd21;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("rr_gnt", 64'({r0.gnt, r1.gnt}), (i % 2 == 0) ? 64'b10 : 64'b01);
            e.cyc = cyc + 1;
            if (i % 2 == 0) begin e.data = VAL_A; q0.push_back(e); end
            else            begin e.data = VAL_B; q1.push_back(e); end
            step();
        end
        r0.vld = 0; r1.vld = 0;

        // Partial, zero-mask and top-address writes.
        access(0, 1'b1, 9'd30, ONES, 54'h3, '0);
        access(1, 1'b0, 9'd30, '0, '0, 54'h3);
        access(0, 1'b1, 9'd7, ONES, '0, '0);
        access(0, 1'b0, 9'd7, '0, '0, 54'h15);
        access(1, 1'b1, 9'd511, VAL_D, ONES, '0);
        access(0, 1'b0, 9'd511, '0, '0, VAL_D);

        // Re-init colliding with a request; the read just before still returns.
        access(1, 1'b0, 9'd21, '0, '0, VAL_B);
        init_start = 1;
        r0.vld = 1; r0.wr = 1; r0.addr = 9'd40; r0.wdata = VAL_C; r0.wmask = ONES;
        @(negedge clk);
        idle_check("init_start_idle");
        chk("init_start_flags", 64'({init_busy, init_done}), 64'b01);
        step();
        init_start = 0;
        for (int k = 0; k < 512; k++) begin
            sweep_check(k);
            step();
        end
        @(negedge clk);
        chk("reinit_flags", 64'({init_busy, init_done}), 64'b01);
        chk("reinit_gnt", 64'({r0.gnt, r1.gnt}), 64'b10);
        chk("reinit_wr", 64'({sram_a, sram_cen, sram_gwen}), 64'({9'd40, 2'b00}));
        step();
        r0.vld = 0;
        access(1, 1'b0, 9'd21, '0, '0, '0);
        access(0, 1'b0, 9'd40, '0, '0, VAL_C);

        // Reset in the middle of a sweep restarts it from address 0.
        init_start = 1;
        step();
        init_start = 0;
        for (int k = 0; k < 200; k++) begin
            sweep_check(k);
            step();
        end
        RST = 1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            idle_check("midrst_idle");
            chk("midrst_a", 64'(sram_a), 64'd0);
            chk("midrst_flags", 64'({init_busy, init_done}), 64'b10);
            step();
        end
        RST = 0;
        for (int k = 0; k < 512; k++) begin
            sweep_check(k);
            step();
        end
        @(negedge clk);
        chk("final_flags", 64'({init_busy, init_done}), 64'b01);
        step(); step(); step();
        chk("q0_drained", 64'(q0.size()), 64'd0);
        chk("q1_drained", 64'(q1.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
